// File: rtl/pit_pkg.sv
// pit_pkg: shared constants and state encoding for the programmable interval timer.
//   PIT_WIDTH   - default width of the prescaler and divider
//   pit_state_e - controller states (IDLE, LOAD, RUN)
package pit_pkg;
  localparam int PIT_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } pit_state_e;
endpackage

// File: rtl/pit_cnt.sv
// pit_cnt: loadable down-counter with asynchronous active-low clear.
//   clk  - system clock
//   resl - asynchronous active-low clear
//   load - load din (takes priority over dec)
//   dec  - decrement by one
//   din  - load value
//   q    - current count
//   zero - high while q == 0
module pit_cnt
  import pit_pkg::*;
#(
  parameter int WIDTH = PIT_WIDTH
) (
  input  logic             clk,
  input  logic             resl,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             zero
);
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) q <= '0;
    else if (load) q <= din;
    else if (dec) q <= q - WIDTH'(1);
  end
  assign zero = (q == '0);
endmodule

// File: rtl/pit_ctrl.sv
// pit_ctrl: programmable interval timer, prescaler chained into divider, tick every (P+1)*(D+1) clocks.
//   clk      - system clock
//   resl     - asynchronous active-low reset
//   pre_wr   - write strobe, captures pre_din as prescaler reload P
//   pre_din  - prescaler reload value
//   div_wr   - write strobe, captures div_din as divider reload D
//   div_din  - divider reload value (0 disables the timer)
//   oneshot  - only with PIT_ONESHOT_EN: stop in IDLE after the next tick
//   pre_q    - current prescaler count
//   div_q    - current divider count
//   running  - high while in RUN
//   tick     - one-clock strobe in the cycle after each period wrap
// Optional build macro: PIT_ONESHOT_EN adds the oneshot input.
module pit_ctrl
  import pit_pkg::*;
#(
  parameter int WIDTH = PIT_WIDTH
) (
  input  logic             clk,
  input  logic             resl,
  input  logic             pre_wr,
  input  logic [WIDTH-1:0] pre_din,
  input  logic             div_wr,
  input  logic [WIDTH-1:0] div_din,
`ifdef PIT_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic [WIDTH-1:0] pre_q,
  output logic [WIDTH-1:0] div_q,
  output logic             running,
  output logic             tick
);
  logic [WIDTH-1:0] pre_reload, div_reload;
  pit_state_e state, state_nxt;
  logic pre_zero, div_zero, in_run, in_load, wr, wrap, stop;
  assign in_run  = (state == RUN);
  assign in_load = (state == LOAD);
  assign wr      = pre_wr | div_wr;
  assign wrap    = in_run & pre_zero & div_zero;
`ifdef PIT_ONESHOT_EN
  assign stop = wrap & oneshot;
`else
  assign stop = 1'b0;
`endif
  // A write always restarts the period; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = wr      ? LOAD :
                in_load ? ((div_reload == '0) ? IDLE : RUN) :
                stop    ? IDLE :
                in_run  ? RUN  : IDLE;
  end
  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      pre_reload <= '0;
      div_reload <= '0;
      state      <= IDLE;
      running    <= 1'b0;
      tick       <= 1'b0;
    end else begin
      if (pre_wr) pre_reload <= pre_din;
      if (div_wr) div_reload <= div_din;
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      tick    <= wrap;
    end
  end
  // The prescaler reloads whenever it expires in RUN; the divider steps only on prescaler expiry.
  pit_cnt #(.WIDTH(WIDTH)) u_pre (
    .clk  (clk),
    .resl (resl),
    .load (in_load | (in_run & pre_zero)),
    .dec  (in_run & ~pre_zero),
    .din  (pre_reload),
    .q    (pre_q),
    .zero (pre_zero)
  );
  pit_cnt #(.WIDTH(WIDTH)) u_div (
    .clk  (clk),
    .resl (resl),
    .load (in_load | wrap),
    .dec  (in_run & pre_zero & ~div_zero),
    .din  (div_reload),
    .q    (div_q),
    .zero (div_zero)
  );
endmodule

// File: tb/tb_pit_ctrl.sv
// tb_pit_ctrl: self-checking bench for pit_ctrl against an elapsed-time arithmetic model.
module tb_pit_ctrl;
  localparam int W = 16;
  logic clk = 1'b0, resl = 1'b0, pre_wr = 1'b0, div_wr = 1'b0;
  logic [W-1:0] pre_din = '0, div_din = '0;
  logic [W-1:0] pre_q, div_q;
  logic running, tick;
`ifdef PIT_ONESHOT_EN
  logic oneshot = 1'b0;
`endif
  int vectors = 0, miscompares = 0;
  int cyc = 0, lw = 0, l0 = 0;
  int ticks[$];
  always #5 clk = ~clk;
  pit_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .resl    (resl),
    .pre_wr  (pre_wr),
    .pre_din (pre_din),
    .div_wr  (div_wr),
    .div_din (div_din),
`ifdef PIT_ONESHOT_EN
    .oneshot (oneshot),
`endif
    .pre_q   (pre_q),
    .div_q   (div_q),
    .running (running),
    .tick    (tick)
  );
  // Model: after LOAD, t counts clocks; remaining = (N-1 - t mod N) splits into div*(P+1)+pre.
  int m_mode = 0;
  logic [W-1:0] m_pr = '0, m_dr = '0, m_p = '0, m_d = '0, m_pre = '0, m_div = '0;
  logic m_tick = 1'b0, m_run = 1'b0;
  longint m_t = 0;
  always @(posedge clk) cyc++;
  always @(posedge clk or negedge resl) begin
    longint n, rem;
    bit os;
    if (!resl) begin
      m_mode = 0; m_pr = '0; m_dr = '0; m_pre = '0; m_div = '0; m_tick = 1'b0; m_run = 1'b0;
    end else begin
      os = 1'b0;
`ifdef PIT_ONESHOT_EN
      os = oneshot;
`endif
      m_tick = 1'b0;
      if (m_mode == 2) begin
        m_t++;
        n = (longint'(m_p) + 1) * (longint'(m_d) + 1);
        rem = n - 1 - (m_t % n);
        m_pre = W'(rem % (longint'(m_p) + 1));
        m_div = W'(rem / (longint'(m_p) + 1));
        m_tick = (m_t % n == 0);
        if (m_tick && os) m_mode = 0;
      end else if (m_mode == 1) begin
        m_p = m_pr; m_d = m_dr; m_t = 0; m_pre = m_pr; m_div = m_dr;
        m_mode = (m_dr == '0) ? 0 : 2;
      end
      if (pre_wr) m_pr = pre_din;
      if (div_wr) m_dr = div_din;
      if (pre_wr || div_wr) m_mode = 1;
      m_run = (m_mode == 2);
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    chk("pre_q", 32'(pre_q), 32'(m_pre));
    chk("div_q", 32'(div_q), 32'(m_div));
    chk("running", 32'(running), 32'(m_run));
    chk("tick", 32'(tick), 32'(m_tick));
    if (tick) ticks.push_back(cyc);
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic pulse(input bit pw, input logic [W-1:0] p, input bit dw, input logic [W-1:0] d);
    pre_wr = pw; pre_din = p; div_wr = dw; div_din = d;
    step(1);
    lw = cyc;
    pre_wr = 1'b0; div_wr = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_pre_q", 32'(pre_q), 0);
    chk("rst_running", 32'(running), 0);
    resl = 1'b1;
    step(2);
    // basic period P=3 D=2: first tick 13 after LOAD, then every 12
    pulse(1, 3, 1, 2);
    step(1); ticks.delete();
    step(40);
    chk("basic_count", 32'(ticks.size() >= 3), 1);
    chk("basic_first", 32'(ticks[0] - lw), 13);
    chk("basic_int1", 32'(ticks[1] - ticks[0]), 12);
    chk("basic_int2", 32'(ticks[2] - ticks[1]), 12);
    // asynchronous reset mid-run
    resl = 1'b0;
    #1;
    chk("arst_pre_q", 32'(pre_q), 0);
    chk("arst_div_q", 32'(div_q), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_tick", 32'(tick), 0);
    step(3);
    resl = 1'b1;
    ticks.delete();
    step(30);
    chk("arst_no_tick", 32'(ticks.size()), 0);
    chk("arst_idle", 32'(running), 0);
    // disable by writing D=0 while running
    pulse(1, 3, 1, 2);
    step(7);
    pulse(0, 0, 1, 0);
    step(1); ticks.delete();
    step(30);
    chk("dis_no_tick", 32'(ticks.size()), 0);
    chk("dis_running", 32'(running), 0);
    chk("dis_pre_q", 32'(pre_q), 3);
    chk("dis_div_q", 32'(div_q), 0);
    // P=0 D=1: tick every 2 clocks
    pulse(1, 0, 1, 1);
    step(1); ticks.delete();
    step(10);
    chk("p0_first", 32'(ticks[0] - lw), 3);
    chk("p0_int1", 32'(ticks[1] - ticks[0]), 2);
    chk("p0_int2", 32'(ticks[2] - ticks[1]), 2);
    // P=FFFF D=0: stays idle
    pulse(1, 16'hFFFF, 1, 0);
    step(1); ticks.delete();
    step(5);
    chk("max_running", 32'(running), 0);
    chk("max_pre_q", 32'(pre_q), 32'hFFFF);
    chk("max_div_q", 32'(div_q), 0);
    chk("max_no_tick", 32'(ticks.size()), 0);
    // write colliding with a wrap: tick still fires, full new period follows
    pulse(1, 1, 1, 1);
    l0 = lw;
    step(l0 + 4 - cyc);
    ticks.delete();
    pulse(1, 1, 0, 0);
    step(15);
    chk("col_tick", 32'(ticks[0]), 32'(l0 + 5));
    chk("col_next", 32'(ticks[1]), 32'(l0 + 10));
    chk("col_int", 32'(ticks[2] - ticks[1]), 4);
`ifdef PIT_ONESHOT_EN
    oneshot = 1'b1;
    pulse(1, 1, 1, 1);
    step(1); ticks.delete();
    step(20);
    chk("os_count", 32'(ticks.size()), 1);
    chk("os_first", 32'(ticks[0] - lw), 5);
    chk("os_running", 32'(running), 0);
    pulse(1, 1, 1, 1);
    step(1); ticks.delete();
    step(10);
    chk("os_rearm_count", 32'(ticks.size()), 1);
    chk("os_rearm", 32'(ticks[0] - lw), 5);
    oneshot = 1'b0;
`endif
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
